mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  EX-stage iterative multiply/divide unit running beside the ALU on the same
//  A/B operands from ID/EX. Executes MULT, MULTU, DIV, DIVU and MTHI/MTLO into
//  the architectural HI/LO registers. Its hi/lo outputs feed the MFHI/MFLO
//  result mux. Hazard logic stalls the pipeline while busy is high.
// PARAMETERS
//  WIDTH  `WORD  operand width; HI and LO are WIDTH bits each
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-high reset
//  start  in   1      issue request; sampled on a clk edge
//  op     in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//  A      in   WIDTH  rs operand (multiplicand / dividend / MTHI, MTLO data)
//  B      in   WIDTH  rt operand (multiplier / divisor)
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
//  busy   out  1      multi-cycle operation in progress
//  done   out  1      one-cycle pulse in the cycle HI/LO take a mul/div result
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; hi=0, lo=0, busy=0, done=0.
//   Any in-flight operation is discarded, and HI/LO are not updated.
//  FSM: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  Acceptance rule: the unit accepts an op only when start=1 and the state is IDLE.
//   While busy=1, start is ignored. Nothing is queued.
//  MTHI/MTLO: accepted at edge k; hi<=A (or lo<=A) at edge k. busy and done stay 0.
//  op 6-7 with start: no state change and no register change.
//  MULT/MULTU/DIV/DIVU accepted at edge k:
//   - Operands are latched at edge k. In signed ops, operand magnitudes are taken here.
//   - After edge k: busy=1.
//   - Edges k+1..k+WIDTH: one RUN iteration each (shift-add or restoring
//     subtract step). An iteration counter counts 0..WIDTH-1.
//   - Edge k+WIDTH+1 (FIX): sign correction; {hi,lo} are written.
//     After this edge: done=1 for exactly one cycle, busy=0, state=IDLE.
//   - busy stays high for exactly WIDTH+1 cycles. A new start in the done
//     cycle is accepted.
//   - A/B may change after edge k without affecting the result.
//  Multiply: {hi,lo} = 2*WIDTH-bit product.
//   MULT is two's-complement. MULTU is unsigned.
//  Divide: lo = quotient, hi = remainder.
//   DIV truncates toward zero. The remainder takes the dividend's sign.
//   DIVU is unsigned.
//  Divide by zero (B=0): lo = all ones, hi = A. Latency and done are
//   unchanged, and there is no exception.
//  DIV of most-negative / -1: lo = most-negative (wraps), hi = 0.
//  hi/lo hold their values at all times except on the write edges above;
//   intermediate RUN values are never visible on hi/lo.
// TESTING
//  1 MULT A=32'hFFFFFFFE(-2), B=32'h00000003 -> after 33 busy cycles:
//    hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulses once.
//  2 MULTU A=B=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
//  3 DIV A=-7 (32'hFFFFFFF9), B=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1);
//    DIVU A=100, B=7 -> lo=14, hi=2.
//  4 DIVU A=32'h12345678, B=0 -> lo=32'hFFFFFFFF, hi=32'h12345678, same latency;
//    DIV A=32'h80000000, B=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
//  5 Issue MULT 5*6, then hold start=1 with op=MTHI, A=32'hDEAD during busy
//    -> MTHI is ignored and the result is hi=0, lo=30; MTLO A=9 issued
//    in the done cycle -> lo=9 on the next edge.
//  6 Assert reset at RUN iteration 10 of a DIV -> busy=0, done=0, hi=lo=0
//    immediately (async); a fresh MULTU 3*4 then yields lo=12 with full latency.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit beside the ALU; owns the architectural HI/LO registers.
// Latency: MTHI/MTLO write on the accepting edge; MULT/DIV write HI/LO WIDTH+1 edges after acceptance.
// Backpressure: busy is high while an operation runs; start is ignored then and nothing is queued.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;     // latched: divide (1) or multiply (0)
    logic             res_neg;    // latched: product / quotient must be negated
    logic             rem_neg;    // latched: remainder takes the dividend's sign
    logic             div_zero;   // latched: divisor was zero
    logic [WIDTH-1:0] b_mag;      // multiplicand or divisor magnitude
    logic [WIDTH:0]   acc;        // product high half / partial remainder
    logic [WIDTH-1:0] q;          // multiplier shifting out / quotient shifting in

    // Operand decode for the accepting edge
    logic             op_mdu;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_abs;

    // Magnitudes and signs of the incoming operands
    always_comb begin
        op_mdu    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & A[WIDTH-1];
        b_neg     = op_signed & B[WIDTH-1];
        a_mag     = a_neg ? (~A + 1'b1) : A;
        b_abs     = b_neg ? (~B + 1'b1) : B;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] q_nx;

    always_comb begin
        mul_sum   = acc + (q[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
        div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_mag};
        acc_nx    = acc;
        q_nx      = q;
        if (is_div) begin
            if (!div_trial[WIDTH]) begin
                acc_nx = div_trial;
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = div_shift;
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx = {1'b0, mul_sum[WIDTH:1]};
            q_nx   = {mul_sum[0], q[WIDTH-1:1]};
        end
    end

    // Sign correction applied in the FIX cycle
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    always_comb begin
        prod_u = {acc[WIDTH-1:0], q};
        prod_s = res_neg ? (~prod_u + 1'b1) : prod_u;
        quo_s  = res_neg ? (~q + 1'b1) : q;
        rem_s  = rem_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        if (is_div) begin
            // Divide by zero leaves quotient all ones regardless of dividend sign
            lo_fix = div_zero ? {WIDTH{1'b1}} : quo_s;
            hi_fix = rem_s;
        end else begin
            lo_fix = prod_s[WIDTH-1:0];
            hi_fix = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM with registered HI/LO, busy and done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            b_mag    <= '0;
            acc      <= '0;
            q        <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op_mdu) begin
                            state    <= S_RUN;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            is_div   <= op[1];
                            res_neg  <= a_neg ^ b_neg;
                            rem_neg  <= a_neg;
                            div_zero <= (B == '0);
                            b_mag    <= b_abs;
                            acc      <= '0;
                            q        <= a_mag;
                        end else if (op == OP_MTHI) begin
                            hi <= A;
                        end else if (op == OP_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_nx;
                    q   <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: products, quotients, corner divides, issue rules, async reset.
// Latency: each mul/div op is expected to hold busy for 33 cycles then pulse done once.
// Backpressure: start held during busy must be ignored; a start in the done cycle is accepted.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge; returns at the done-cycle negedge
    task automatic wait_result(input string tag, input logic [31:0] eh, input logic [31:0] el);
        int          nb;
        bit          held;
        logic [31:0] h0;
        logic [31:0] l0;
        nb   = 0;
        held = 1'b1;
        h0   = hi;
        l0   = lo;
        while (busy === 1'b1 && nb < 100) begin
            if (hi !== h0 || lo !== l0) held = 1'b0;
            nb++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, nb, 32'd33);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        chk({tag, " hilo_held"}, {31'd0, held}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        wait_result(tag, eh, el);
        @(negedge clk);
        chk({tag, " done_once"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        #1;
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Multiplies
        run_op("mult_neg",   3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_minsq", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        // Divides
        run_op("div_neg",    3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negb",   3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run_op("divu",       3'd3, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("divu_zero",  3'd3, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
        run_op("div_zero",   3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // MTHI / MTLO and no-op
        start = 1'b1; op = 3'd4; A = 32'h0000CAFE;
        @(negedge clk);
        start = 1'b0;
        chk("mthi hi", hi, 32'h0000CAFE);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("mthi done", {31'd0, done}, 32'd0);
        start = 1'b1; op = 3'd6; A = 32'h11111111; B = 32'h22222222;
        @(negedge clk);
        start = 1'b0;
        chk("nop hi", hi, 32'h0000CAFE);
        chk("nop lo", lo, 32'h80000000);
        chk("nop busy", {31'd0, busy}, 32'd0);

        // Start held high with MTHI during busy is ignored; MTLO in the done cycle is taken
        start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd6;
        @(negedge clk);
        op = 3'd4; A = 32'h0000DEAD;
        wait_result("mult_hold", 32'd0, 32'd30);
        op = 3'd5; A = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_done lo", lo, 32'd9);
        chk("mtlo_done hi", hi, 32'd0);
        chk("mtlo_done done", {31'd0, done}, 32'd0);
        chk("mtlo_done busy", {31'd0, busy}, 32'd0);

        // Async reset in the middle of a divide
        start = 1'b1; op = 3'd2; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst busy", {31'd0, busy}, 32'd0);
        chk("mid_rst done", {31'd0, done}, 32'd0);
        chk("mid_rst hi", hi, 32'd0);
        chk("mid_rst lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst busy", {31'd0, busy}, 32'd0);
        run_op("multu_after_rst", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
